// File: rtl/mem_loader_pkg.sv
// rtl/mem_loader_pkg.sv - shared constants and state encoding for the memory image loader
package mem_loader_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 512;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/loader_addr_gen.sv
// rtl/loader_addr_gen.sv - base/count/length tracker producing the wrapped byte address and last flag
//   clk, reset          : clock, synchronous active-high reset
//   load                : latch base_in/length_in and clear count
//   clear               : clear count only (keeps base and length)
//   step                : advance count by one
//   addr                : (base + count) mod 2**ADDR_W
//   last                : count is on the final byte of the region
module loader_addr_gen #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] base_in,
    input  logic [ADDR_W:0]   length_in,
    input  logic              clear,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    import mem_loader_pkg::*;

    localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            base_q  <= '0;
            len_q   <= '0;
            count_q <= '0;
        end else if (load) begin
            base_q  <= base_in;
            len_q   <= length_in;
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (step) begin
            count_q <= count_q + ONE;
        end
    end

    // Memory size is a power of two, so dropping the carry is the modulo wrap.
    assign addr = base_q + count_q[ADDR_W-1:0];
    assign last = (count_q == len_q - ONE);

endmodule

// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - streams a program image into memory, reads it back to verify, holds the core meanwhile
//   clk, reset          : clock, synchronous active-high reset
//   start, base_addr, length : load request (sampled in IDLE only)
//   s_valid, s_data, s_ready : incoming image byte stream
//   mem_we, mem_addr, mem_wdata, mem_rdata : shared memory port (rdata combinational)
//   busy, cpu_hold, done, error, checksum  : status
module mem_loader #(
    parameter int ADDR_W = mem_loader_pkg::ADDR_W,
    parameter int DATA_W = mem_loader_pkg::DATA_W,
    parameter int DEPTH  = mem_loader_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] checksum
);
    import mem_loader_pkg::*;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_t            state, next_state;
    logic [DATA_W-1:0] vsum;
    logic [DATA_W-1:0] vsum_next;
    logic              err_q;
    logic              length_ok;
    logic              ag_load, ag_clear, ag_step;
    logic [ADDR_W-1:0] ag_addr;
    logic              ag_last;

    loader_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .load      (ag_load),
        .base_in   (base_addr),
        .length_in (length),
        .clear     (ag_clear),
        .step      (ag_step),
        .addr      (ag_addr),
        .last      (ag_last)
    );

    assign length_ok = (length != '0) && (length <= DEPTH_L);
    assign vsum_next = vsum + mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            checksum <= '0;
            vsum     <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (length_ok) begin
                            checksum <= '0;
                            vsum     <= '0;
                            err_q    <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (s_valid) begin
                        checksum <= checksum + s_data;
                    end
                end
                VERIFY: begin
                    vsum <= vsum_next;
                    // Compare the read-back sum including the byte on the bus this cycle.
                    if (ag_last) begin
                        err_q <= (vsum_next != checksum);
                    end
                end
                DONE: begin
                    err_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        s_ready    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        busy       = 1'b0;
        cpu_hold   = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        ag_load    = 1'b0;
        ag_clear   = 1'b0;
        ag_step    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (length_ok) begin
                        ag_load    = 1'b1;
                        next_state = LOAD;
                    end else begin
                        next_state = DONE;
                    end
                end
            end
            LOAD: begin
                s_ready  = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
                mem_addr = ag_addr;
                if (s_valid) begin
                    mem_we    = 1'b1;
                    mem_wdata = s_data;
                    if (ag_last) begin
                        ag_clear   = 1'b1;
                        next_state = VERIFY;
                    end else begin
                        ag_step = 1'b1;
                    end
                end
            end
            VERIFY: begin
                busy     = 1'b1;
                cpu_hold = 1'b1;
                mem_addr = ag_addr;
                ag_step  = 1'b1;
                if (ag_last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                cpu_hold   = 1'b1;
                done       = 1'b1;
                error      = err_q;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_loader.sv
// tb/tb_mem_loader.sv - table-driven self-checking bench for mem_loader
module tb_mem_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [8:0] base_addr;
    logic [9:0] length;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       mem_we;
    logic [8:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy;
    logic       cpu_hold;
    logic       done;
    logic       error;
    logic [7:0] checksum;

    mem_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    // Memory model; flip_en corrupts bit 0 of whatever lands at address 2.
    logic [7:0] mem [512];
    bit         flip_en = 1'b0;
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata ^ ((flip_en && mem_addr == 9'd2) ? 8'h01 : 8'h00);
    end
    assign mem_rdata = mem[mem_addr];

    // Monitor
    int cyc = 0;
    int start_cyc = 0;
    int done_cnt, hold_cnt, done_cyc;
    bit err_at_done;
    logic [8:0] wq_addr[$];
    int         wq_cyc[$];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (mem_we) begin
            wq_addr.push_back(mem_addr);
            wq_cyc.push_back(cyc - start_cyc);
        end
        if (cpu_hold) hold_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc    = cyc - start_cyc;
            err_at_done = error;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [8:0]      base;
        logic [9:0]      len;
        logic [3:0][7:0] d;
        int              gap_after;
        int              gap_len;
        bit              corrupt;
        logic [3:0][8:0] exp_addr;
        logic [3:0][7:0] exp_wcyc;
        logic [7:0]      exp_sum;
        bit              exp_err;
        int              exp_done;
    } vec_t;

    vec_t vecs[4];

    task automatic clear_logs();
        wq_addr.delete();
        wq_cyc.delete();
        done_cnt    = 0;
        hold_cnt    = 0;
        done_cyc    = -1;
        err_at_done = 1'b0;
    endtask

    // abort_after >= 0: assert reset once that many bytes were accepted, then return.
    task automatic run_load(input int v, input int abort_after);
        int i;
        int gap_left;
        bit aborted;
        i        = 0;
        gap_left = vecs[v].gap_len;
        aborted  = 1'b0;
        clear_logs();
        flip_en = vecs[v].corrupt;
        @(posedge clk); #1;
        start_cyc = cyc;
        base_addr = vecs[v].base;
        length    = vecs[v].len;
        start     = 1'b1;
        s_valid   = 1'b0;
        for (int c = 0; c < 100 && done_cnt == 0 && !aborted; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (abort_after >= 0 && i == abort_after) begin
                reset   = 1'b1;
                s_valid = 1'b0;
                aborted = 1'b1;
            end else begin
                if (i < int'(vecs[v].len) && !(i == vecs[v].gap_after && gap_left > 0)) begin
                    s_valid = 1'b1;
                    s_data  = vecs[v].d[i];
                end else begin
                    s_valid = 1'b0;
                    if (i == vecs[v].gap_after && gap_left > 0) gap_left--;
                end
                #1;
                if (s_valid && s_ready) i++;
            end
        end
        s_valid = 1'b0;
        if (!aborted) begin
            repeat (3) @(posedge clk);
            #1;
            flip_en = 1'b0;
            check($sformatf("v%0d done_count", v), done_cnt, 1);
            check($sformatf("v%0d done_cycle", v), done_cyc, vecs[v].exp_done);
            check($sformatf("v%0d error", v), err_at_done, vecs[v].exp_err);
            check($sformatf("v%0d checksum", v), checksum, vecs[v].exp_sum);
            check($sformatf("v%0d hold_cycles", v), hold_cnt, vecs[v].exp_done);
            check($sformatf("v%0d write_count", v), wq_addr.size(), vecs[v].len);
            for (int k = 0; k < 4 && k < wq_addr.size(); k++) begin
                logic [7:0] want;
                want = vecs[v].d[k] ^ ((vecs[v].corrupt && vecs[v].exp_addr[k] == 9'd2) ? 8'h01 : 8'h00);
                check($sformatf("v%0d w%0d addr", v, k), wq_addr[k], vecs[v].exp_addr[k]);
                check($sformatf("v%0d w%0d cycle", v, k), wq_cyc[k], vecs[v].exp_wcyc[k]);
                check($sformatf("v%0d w%0d mem", v, k), mem[vecs[v].exp_addr[k]], want);
            end
        end
    endtask

    task automatic run_bad(input logic [9:0] len, input logic [7:0] prev_sum);
        clear_logs();
        @(posedge clk); #1;
        start_cyc = cyc;
        base_addr = 9'd0;
        length    = len;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check($sformatf("bad%0d done_count", len), done_cnt, 1);
        check($sformatf("bad%0d done_cycle", len), done_cyc, 1);
        check($sformatf("bad%0d error", len), err_at_done, 1);
        check($sformatf("bad%0d writes", len), wq_addr.size(), 0);
        check($sformatf("bad%0d hold_cycles", len), hold_cnt, 1);
        check($sformatf("bad%0d checksum_kept", len), checksum, prev_sum);
    endtask

    initial begin
        for (int a = 0; a < 512; a++) mem[a] = 8'h00;
        reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; s_valid = 1'b0; s_data = '0;

        vecs[0] = '{base: 9'd0, len: 10'd4, d: {8'h00, 8'h10, 8'h05, 8'h13},
                    gap_after: -1, gap_len: 0, corrupt: 1'b0,
                    exp_addr: {9'd3, 9'd2, 9'd1, 9'd0}, exp_wcyc: {8'd4, 8'd3, 8'd2, 8'd1},
                    exp_sum: 8'h28, exp_err: 1'b0, exp_done: 9};
        vecs[1] = '{base: 9'd0, len: 10'd4, d: {8'h00, 8'h10, 8'h05, 8'h13},
                    gap_after: 2, gap_len: 3, corrupt: 1'b0,
                    exp_addr: {9'd3, 9'd2, 9'd1, 9'd0}, exp_wcyc: {8'd7, 8'd6, 8'd2, 8'd1},
                    exp_sum: 8'h28, exp_err: 1'b0, exp_done: 12};
        vecs[2] = '{base: 9'd510, len: 10'd4, d: {8'hDD, 8'hCC, 8'hBB, 8'hAA},
                    gap_after: -1, gap_len: 0, corrupt: 1'b0,
                    exp_addr: {9'd1, 9'd0, 9'd511, 9'd510}, exp_wcyc: {8'd4, 8'd3, 8'd2, 8'd1},
                    exp_sum: 8'h0E, exp_err: 1'b0, exp_done: 9};
        vecs[3] = '{base: 9'd0, len: 10'd4, d: {8'h00, 8'h10, 8'h05, 8'h13},
                    gap_after: -1, gap_len: 0, corrupt: 1'b1,
                    exp_addr: {9'd3, 9'd2, 9'd1, 9'd0}, exp_wcyc: {8'd4, 8'd3, 8'd2, 8'd1},
                    exp_sum: 8'h28, exp_err: 1'b1, exp_done: 9};

        repeat (3) @(posedge clk);
        #1;
        check("rst s_ready", s_ready, 0);
        check("rst mem_we", mem_we, 0);
        check("rst busy", busy, 0);
        check("rst cpu_hold", cpu_hold, 0);
        check("rst done", done, 0);
        check("rst error", error, 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst mem_wdata", mem_wdata, 0);
        check("rst checksum", checksum, 0);
        reset = 1'b0;

        for (int v = 0; v < 4; v++) run_load(v, -1);

        run_bad(10'd0, 8'h28);
        run_bad(10'd513, 8'h28);

        // Reset after two of four bytes
        run_load(0, 2);
        @(posedge clk); #1;
        check("midrst cpu_hold", cpu_hold, 0);
        check("midrst busy", busy, 0);
        check("midrst s_ready", s_ready, 0);
        check("midrst checksum", checksum, 0);
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("midrst done_never", done_cnt, 0);
        check("midrst writes", wq_addr.size(), 2);
        run_load(0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
